bcd_bin: RTL and testbench
==========================

Name: bcd_bin

Overview:
- Iterative BCD-to-binary converter; the inverse of the team's binary-to-BCD block.
- Converts a packed BCD value of DIGITS digits into an unsigned binary word.
- Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from any digit ≥8.
- Sits between keypad/display-entry logic and arithmetic datapaths. Uses a start/busy/done handshake and a registered result.

Parameters:
- DIGITS, 6, number of packed BCD digits on the input.
- BW, 20, output binary width. Must satisfy 2^BW > 10^DIGITS-1; this is also the iteration count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD; digit 0 in [3:0]; sampled on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; result valid.
- bin  output  BW  binary result; holds its value until the next done.
- err  output  1  invalid-digit flag; see Optional Feature.

Behaviour:
- Reset: one clock (clk); asynchronous, active-low reset (rst_n). Assertion at any time, including mid-conversion, forces:
  - state=IDLE, counter=0, shift register=0;
  - busy=0, done=0, bin=0, err=0.
  - The conversion in progress is discarded and no done is produced.
- States: IDLE, CONV.
- IDLE:
  - done deasserts after one cycle.
  - On an edge with start=1: load shift register {bcd, BW'b0}, clear counter, go to CONV, busy<=1.
  - start=0 leaves all outputs unchanged.
- CONV, each edge:
  - Logical right-shift the whole (4*DIGITS+BW)-bit register by 1.
  - Then, in the shifted BCD field, replace every 4-bit digit ≥8 with digit-3; all digits are evaluated in parallel, same edge.
  - Increment counter.
  - On the edge completing iteration BW: bin <= low BW bits (post-shift), done<=1, busy<=0, state->IDLE.
- Latency: start accepted at edge k. done is high for exactly the cycle following edge k+BW (k+20 by default). busy is high from after edge k until edge k+BW.
- Throughput: a new start can be accepted at edge k+BW+1 (the cycle done is high). Minimum spacing between accepts is BW+1 edges.
- start while busy=1: ignored, no queuing. bcd changes during CONV have no effect.
- start held high continuously: conversions repeat every BW+1 edges.
- Arithmetic: unsigned; no saturation. Any all-valid input (digits 0-9) yields the exact value, at most 10^DIGITS-1.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: BCD_BIN_CHECK_EN.
- Defined:
  - At the accepting edge, any digit >9 sets an internal invalid flag.
  - Conversion still runs the full BW cycles.
  - At completion: err<=1 and bin<=0 together with done.
  - err holds until the next accepting edge, where it clears to 0.
- Not defined:
  - err is tied to constant 0.
  - Invalid digits pass through the algorithm unchecked; bin is deterministic but unspecified.
- The port list is identical in both builds.

Test Plan:
- Reset release, then bcd=24'h000000, start pulse -> done exactly 20 cycles after accept; bin=20'h00000; busy high 20 cycles.
- bcd=24'h999999 -> bin=20'hF423F. bcd=24'h123456 -> bin=20'h1E240. bcd=24'h065535 -> bin=20'h0FFFF.
- start held high with bcd=24'h000001, then 24'h000010 -> results 1 and 10 (20'h0000A), accepts 21 edges apart; start pulses during busy are ignored.
- Accept 24'h999999, drop rst_n at cycle 10, release, then convert 24'h000042 -> no done before reset; bin=0 after reset; next result 20'h0002A.
- With BCD_BIN_CHECK_EN, bcd=24'h00000A -> done with err=1, bin=0. Next bcd=24'h000007 -> err=0, bin=7. Without the macro, err stays 0 throughout.

Source files
------------

// File: rtl/bcd_bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one bit per clock.
// Define BCD_BIN_CHECK_EN to flag invalid input digits (err=1, bin=0 on completion).
module bcd_bin #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BW     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BW-1:0]         bin,
  output logic                  err
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned SW = DW + BW;
  localparam int unsigned CW = $clog2(BW + 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_sr;
  logic [SW-1:0]   w_sr_step;
  logic [BW-1:0]   r_bin;
  logic [BW-1:0]   w_bin_nxt;
  logic            r_done;
  logic            w_accept;
  logic            w_last;

  assign w_accept = (r_state == StIdle) && start;
  assign w_last   = (r_state == StConv) && (r_cnt == CW'(BW - 1));

  // One iteration: shift right, then pull every BCD digit >= 8 back down by 3.
  always_comb begin
    w_sr_step = r_sr >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_sr_step[BW+4*d +: 4] >= 4'd8) begin
        w_sr_step[BW+4*d +: 4] = w_sr_step[BW+4*d +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start)  w_state_nxt = StConv;
      StConv:  if (w_last) w_state_nxt = StIdle;
      default:             w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StConv);
    done = r_done;
    bin  = r_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sr   <= '0;
      r_bin  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sr  <= {bcd, {BW{1'b0}}};
        r_cnt <= '0;
      end else if (r_state == StConv) begin
        r_sr  <= w_sr_step;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_done <= 1'b1;
          r_bin  <= w_bin_nxt;
        end
      end
    end
  end

`ifdef BCD_BIN_CHECK_EN
  logic r_inv;
  logic r_err;
  logic w_bcd_bad;

  always_comb begin
    w_bcd_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] > 4'd9) w_bcd_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_inv <= w_bcd_bad;
      r_err <= 1'b0;
    end else if (w_last) begin
      r_err <= r_inv;
    end
  end

  assign w_bin_nxt = r_inv ? '0 : w_sr_step[BW-1:0];
  assign err       = r_err;
`else
  assign w_bin_nxt = w_sr_step[BW-1:0];
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_bin.sv
// Self-checking bench for bcd_bin: directed vectors, random vectors against a decimal model,
// handshake timing, mid-conversion reset and the invalid-digit flag.
module tb_bcd_bin;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned BW     = 20;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] bcd   = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [19:0] bin;

  int n_vec   = 0;
  int n_bad   = 0;
  bit overlap = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap = 1'b1;

  bcd_bin #(
    .DIGITS (DIGITS),
    .BW     (BW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  // Reference: plain decimal interpretation of the digits.
  function automatic logic [19:0] ref_val(input logic [23:0] v);
    int acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return 20'(acc);
  endfunction

  function automatic bit has_bad_digit(input logic [23:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Call #1 after a rising edge. Returns #1 after the edge on which done was seen.
  task automatic run_conv(input logic [23:0] v, output logic [19:0] b, output logic e,
                          output int lat, output int busy_cnt);
    start    = 1'b1;
    bcd      = v;
    @(posedge clk); #1;
    start    = 1'b0;
    bcd      = 24'($urandom);
    lat      = -1;
    busy_cnt = 0;
    for (int n = 1; n <= int'(BW) + 5; n++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    b = bin;
    e = err;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (bin !== 20'h0) begin n_bad++; $display("FAIL reset_bin: got %h want 0", bin); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [19:0] b; logic e; int lat; int bc;
    logic [19:0] held;
    run_conv(24'h000000, b, e, lat, bc);
    n_vec++; if (lat != int'(BW)) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", lat, BW); end
    n_vec++; if (bc != int'(BW)) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d want %0d", bc, BW); end
    n_vec++; if (b !== 20'h0) begin n_bad++; $display("FAIL zero_bin: got %h want 00000", b); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL zero_err: got %b want 0", e); end
    held = b;
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
    n_vec++; if (bin !== held) begin n_bad++; $display("FAIL bin_hold: got %h want %h", bin, held); end
  endtask

  task automatic test_directed();
    logic [23:0] vin [3] = '{24'h999999, 24'h123456, 24'h065535};
    logic [19:0] vexp[3] = '{20'hF423F, 20'h1E240, 20'h0FFFF};
    logic [19:0] b; logic e; int lat; int bc;
    for (int i = 0; i < 3; i++) begin
      run_conv(vin[i], b, e, lat, bc);
      n_vec++;
      if (lat != int'(BW)) begin
        n_bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, BW);
      end
      n_vec++;
      if (b !== vexp[i]) begin
        n_bad++; $display("FAIL directed_bin[%0d]: got %h want %h", i, b, vexp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] b; logic e; int lat; int bc;
    logic [23:0] v;
    logic [19:0] exp_b;
    logic        exp_e;
    for (int k = 0; k < 40; k++) begin
      v = '0;
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD_BIN_CHECK_EN
      if ($urandom_range(0, 3) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      exp_e = has_bad_digit(v);
      exp_b = exp_e ? 20'h0 : ref_val(v);
`else
      exp_e = 1'b0;
      exp_b = ref_val(v);
`endif
      run_conv(v, b, e, lat, bc);
      n_vec++;
      if (b !== exp_b || e !== exp_e || lat != int'(BW)) begin
        n_bad++;
        $display("FAIL random[%0d] bcd=%h: got bin=%h err=%b lat=%0d want bin=%h err=%b lat=%0d",
                 k, v, b, e, lat, exp_b, exp_e, BW);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1;
    int lat2 = -1;
    logic [19:0] b1;
    start = 1'b1;
    bcd   = 24'h000001;
    @(posedge clk); #1;
    bcd   = 24'h000010;
    for (int n = 1; n <= int'(BW) + 5; n++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = n; break; end
    end
    b1 = bin;
    for (int n = 1; n <= int'(BW) + 6; n++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = n; break; end
    end
    start = 1'b0;
    n_vec++; if (lat1 != int'(BW)) begin n_bad++; $display("FAIL b2b_latency1: got %0d want %0d", lat1, BW); end
    n_vec++; if (b1 !== 20'h00001) begin n_bad++; $display("FAIL b2b_bin1: got %h want 00001", b1); end
    n_vec++; if (lat2 != int'(BW) + 1) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", lat2, BW + 1); end
    n_vec++; if (bin !== 20'h0000A) begin n_bad++; $display("FAIL b2b_bin2: got %h want 0000A", bin); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    start = 1'b1;
    bcd   = 24'h000250;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= int'(BW) + 5; n++) begin
      if (n == 5) begin start = 1'b1; bcd = 24'h000777; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = n; break; end
    end
    n_vec++; if (lat != int'(BW)) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, BW); end
    n_vec++; if (bin !== 20'h000FA) begin n_bad++; $display("FAIL ignore_bin: got %h want 000FA", bin); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] b; logic e; int lat; int bc;
    bit done_seen = 1'b0;
    start = 1'b1;
    bcd   = 24'h999999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (bin !== 20'h0) begin n_bad++; $display("FAIL midrst_bin: got %h want 0", bin); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < int'(BW) + 5; n++) begin
      if (done || busy) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL midrst_resumed: got activity=%b want 0", done_seen); end
    run_conv(24'h000042, b, e, lat, bc);
    n_vec++; if (b !== 20'h0002A || lat != int'(BW)) begin
      n_bad++; $display("FAIL midrst_next: got bin=%h lat=%0d want bin=0002A lat=%0d", b, lat, BW);
    end
  endtask

  task automatic test_err();
    logic [19:0] b; logic e; int lat; int bc;
    run_conv(24'h00000A, b, e, lat, bc);
`ifdef BCD_BIN_CHECK_EN
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", e); end
    n_vec++; if (b !== 20'h0) begin n_bad++; $display("FAIL err_bin_zero: got %h want 0", b); end
    @(posedge clk); #1;
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_hold: got %b want 1", err); end
`else
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_tied: got %b want 0", e); end
`endif
    n_vec++; if (lat != int'(BW)) begin n_bad++; $display("FAIL err_latency: got %0d want %0d", lat, BW); end
    run_conv(24'h000007, b, e, lat, bc);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", e); end
    n_vec++; if (b !== 20'h00007) begin n_bad++; $display("FAIL err_next_bin: got %h want 00007", b); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_err();
    n_vec++;
    if (overlap !== 1'b0) begin n_bad++; $display("FAIL busy_done_overlap: got %b want 0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
